// File: rtl/demux_pkg.sv
// demux_pkg: shared constants and types for the 1-to-4 stream demultiplexer.
//   N_LANES      - number of output lanes
//   SEL_W        - width of the lane select (in_sel)
//   lane_state_t - per-lane holding state (LANE_EMPTY / LANE_FULL)
package demux_pkg;

  localparam int N_LANES = 4;
  localparam int SEL_W   = 2;

  typedef enum logic {
    LANE_EMPTY = 1'b0,
    LANE_FULL  = 1'b1
  } lane_state_t;

endpackage

// File: rtl/demux_lane_reg.sv
// demux_lane_reg: one output lane of the demultiplexer, a one-entry holding
// register with a valid/ready handshake on its output side.
//
// Optional feature: macro DEMUX_COUNT_EN adds a CNT_W-bit counter of
// downstream transfers (wraps, cleared by rst only) and the cnt port.
//
// Ports:
//   clk       in   clock, rising edge
//   rst       in   asynchronous active-high reset (lane EMPTY, data/count 0)
//   flush     in   synchronous clear of the lane to EMPTY
//   load      in   upstream transfer addressed to this lane this cycle
//   load_data in   payload to capture when load=1
//   ready     in   downstream accept
//   valid     out  lane holds a word
//   data      out  held payload
//   cnt       out  downstream transfer count (DEMUX_COUNT_EN only)
module demux_lane_reg
  import demux_pkg::*;
#(
  parameter int DATA_W = 8
`ifdef DEMUX_COUNT_EN
  ,
  parameter int CNT_W  = 16
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              ready,
  output logic              valid,
  output logic [DATA_W-1:0] data
`ifdef DEMUX_COUNT_EN
  ,
  output logic [CNT_W-1:0]  cnt
`endif
);

  lane_state_t       state_reg, state_next;
  logic [DATA_W-1:0] data_reg, data_next;

  // The top only raises load when the lane is EMPTY or draining this cycle,
  // so a load always wins over the drain and gives back-to-back throughput.
  always_comb begin
    state_next = state_reg;
    data_next  = data_reg;
    if (flush) begin
      state_next = LANE_EMPTY;
    end else if (load) begin
      state_next = LANE_FULL;
      data_next  = load_data;
    end else if (state_reg == LANE_FULL && ready) begin
      state_next = LANE_EMPTY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= LANE_EMPTY;
      data_reg  <= '0;
    end else begin
      state_reg <= state_next;
      data_reg  <= data_next;
    end
  end

  assign valid = (state_reg == LANE_FULL);
  assign data  = data_reg;

`ifdef DEMUX_COUNT_EN
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  // A flush cycle overrides the downstream handshake, so it is not counted.
  always_comb begin
    cnt_next = cnt_reg;
    if (!flush && state_reg == LANE_FULL && ready) begin
      cnt_next = cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign cnt = cnt_reg;
`endif

endmodule

// File: rtl/demux1to4_stream.sv
// demux1to4_stream: routes a valid/ready stream to one of four output lanes
// selected per word by in_sel. Each lane is a one-entry register, so a stalled
// lane only blocks words addressed to it.
//
// Optional feature: macro DEMUX_COUNT_EN adds per-lane downstream transfer
// counters and the out_cnt port.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   flush      in   synchronous clear of all lanes; blocks upstream that cycle
//   in_valid   in   upstream word present
//   in_ready   out  upstream word accepted this cycle (combinational)
//   in_sel     in   destination lane 0..3
//   in_data    in   upstream payload
//   out_valid  out  per-lane word present (bit k = lane k)
//   out_ready  in   per-lane downstream accept
//   out_data   out  lane k payload at [k*DATA_W +: DATA_W]
//   out_cnt    out  lane k transfer count at [k*CNT_W +: CNT_W] (DEMUX_COUNT_EN)
module demux1to4_stream
  import demux_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [SEL_W-1:0]          in_sel,
  input  logic [DATA_W-1:0]         in_data,
  output logic [N_LANES-1:0]        out_valid,
  input  logic [N_LANES-1:0]        out_ready,
  output logic [N_LANES*DATA_W-1:0] out_data
`ifdef DEMUX_COUNT_EN
  ,
  output logic [N_LANES*CNT_W-1:0]  out_cnt
`endif
);

  if (DATA_W < 1 || CNT_W < 1) begin : g_param_check
    $error("demux1to4_stream: DATA_W and CNT_W must be at least 1");
  end

  logic [N_LANES-1:0] load;

  // Ready looks only at the addressed lane: it can take a word if empty, or
  // if it is being drained in this same cycle.
  assign in_ready = !flush && (!out_valid[in_sel] || out_ready[in_sel]);

  for (genvar gi = 0; gi < N_LANES; gi++) begin : g_lane
    assign load[gi] = in_valid && in_ready && (in_sel == SEL_W'(gi));

    demux_lane_reg #(
      .DATA_W   (DATA_W)
`ifdef DEMUX_COUNT_EN
      ,
      .CNT_W    (CNT_W)
`endif
    ) u_lane (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .load      (load[gi]),
      .load_data (in_data),
      .ready     (out_ready[gi]),
      .valid     (out_valid[gi]),
      .data      (out_data[gi*DATA_W +: DATA_W])
`ifdef DEMUX_COUNT_EN
      ,
      .cnt       (out_cnt[gi*CNT_W +: CNT_W])
`endif
    );
  end

endmodule

// File: tb/tb_demux1to4_stream.sv
// Testbench for demux1to4_stream: a vector table for the basic/back-pressure
// flow, hand-written multi-cycle sequences (streaming, flush, async reset,
// optional counter wrap), then randomized traffic against a lane model.
module tb_demux1to4_stream;

  localparam int TB_DATA_W = 8;
  localparam int TB_CNT_W  = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_sel;
  logic [7:0]  in_data;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [31:0] out_data;
`ifdef DEMUX_COUNT_EN
  logic [15:0] out_cnt;
`endif

  int errors = 0;
  int checks = 0;

  demux1to4_stream #(
    .DATA_W (TB_DATA_W),
    .CNT_W  (TB_CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel    (in_sel),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef DEMUX_COUNT_EN
    ,
    .out_cnt   (out_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       fl;
    logic       v;
    logic [1:0] sel;
    logic [7:0] d;
    logic [3:0] ordy;
    logic       exp_rdy;
    logic [3:0] exp_ov;
    logic       chk_en;
    int         chk_lane;
    logic [7:0] chk_data;
  } vec_t;

  vec_t vecs[10];

  // Reference lane model: one slot per lane plus a transfer count.
  bit       m_full[4];
  bit [7:0] m_data[4];
  int       m_cnt[4];

  function automatic logic [7:0] lane_data(input int k);
    return out_data[k*8 +: 8];
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Called just after a rising edge; drives inputs and lets in_ready settle.
  task automatic apply(input logic f, input logic v, input logic [1:0] s,
                       input logic [7:0] d, input logic [3:0] r);
    flush     = f;
    in_valid  = v;
    in_sel    = s;
    in_data   = d;
    out_ready = r;
    #1;
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    apply(1'b0, 1'b0, 2'd0, 8'h00, 4'h0);
    rst = 1'b1;
    #2;
    rst = 1'b0;
    edge_step();
    for (int k = 0; k < 4; k++) begin
      m_full[k] = 1'b0;
      m_data[k] = 8'h00;
      m_cnt[k]  = 0;
    end
  endtask

  task automatic rand_cycle(input int n);
    logic       f, v, exp_rdy;
    logic [1:0] s;
    logic [7:0] d;
    logic [3:0] r, exp_ov;
    bit         up, dn;
    f = ($urandom_range(0, 19) == 0);
    v = ($urandom_range(0, 3) != 0);
    s = 2'($urandom_range(0, 3));
    d = 8'($urandom);
    r = 4'($urandom);
    apply(f, v, s, d, r);
    exp_rdy = !f && (!m_full[s] || r[s]);
    chk("rand in_ready", 32'(in_ready), 32'(exp_rdy));
    if (v && exp_rdy) $display("rand %0d: word %h -> lane %0d", n, d, s);
    for (int k = 0; k < 4; k++) begin
      if (f) begin
        m_full[k] = 1'b0;
      end else begin
        up = v && exp_rdy && (s == 2'(k));
        dn = m_full[k] && r[k];
        if (dn) m_cnt[k] = (m_cnt[k] + 1) % (1 << TB_CNT_W);
        if (up) begin
          m_full[k] = 1'b1;
          m_data[k] = d;
        end else if (dn) begin
          m_full[k] = 1'b0;
        end
      end
    end
    edge_step();
    for (int k = 0; k < 4; k++) exp_ov[k] = m_full[k];
    chk("rand out_valid", 32'(out_valid), 32'(exp_ov));
    for (int k = 0; k < 4; k++) begin
      if (m_full[k]) chk("rand out_data", 32'(lane_data(k)), 32'(m_data[k]));
`ifdef DEMUX_COUNT_EN
      chk("rand out_cnt", 32'(out_cnt[k*4 +: 4]), 32'(m_cnt[k]));
`endif
    end
  endtask

  initial begin
    // ---------------- reset state ----------------
    rst = 1'b1;
    flush = 1'b0; in_valid = 1'b0; in_sel = 2'd0; in_data = 8'h00; out_ready = 4'h0;
    edge_step();
    chk("reset out_valid", 32'(out_valid), 32'h0);
    chk("reset out_data", out_data, 32'h0);
`ifdef DEMUX_COUNT_EN
    chk("reset out_cnt", 32'(out_cnt), 32'h0);
`endif
    rst = 1'b0;
    edge_step();
    chk("post-reset in_ready", 32'(in_ready), 32'h1);
    chk("post-reset out_valid", 32'(out_valid), 32'h0);

    // ---------------- vector table ----------------
    //            fl    v     sel   d      ordy   rdy   ov       en   lane data
    vecs[0] = '{1'b0, 1'b1, 2'd2, 8'hA5, 4'hF, 1'b1, 4'b0100, 1'b1, 2, 8'hA5};
    vecs[1] = '{1'b0, 1'b0, 2'd2, 8'h00, 4'hF, 1'b1, 4'b0000, 1'b0, 0, 8'h00};
    vecs[2] = '{1'b0, 1'b1, 2'd1, 8'h11, 4'h0, 1'b1, 4'b0010, 1'b1, 1, 8'h11};
    vecs[3] = '{1'b0, 1'b1, 2'd1, 8'h22, 4'h0, 1'b0, 4'b0010, 1'b1, 1, 8'h11};
    vecs[4] = '{1'b0, 1'b1, 2'd3, 8'h33, 4'h0, 1'b1, 4'b1010, 1'b1, 3, 8'h33};
    vecs[5] = '{1'b0, 1'b1, 2'd1, 8'h44, 4'h2, 1'b1, 4'b1010, 1'b1, 1, 8'h44};
    vecs[6] = '{1'b0, 1'b1, 2'd0, 8'h55, 4'h8, 1'b1, 4'b0011, 1'b1, 0, 8'h55};
    vecs[7] = '{1'b0, 1'b1, 2'd2, 8'h66, 4'h0, 1'b1, 4'b0111, 1'b1, 2, 8'h66};
    vecs[8] = '{1'b1, 1'b1, 2'd3, 8'h77, 4'hF, 1'b0, 4'b0000, 1'b0, 0, 8'h00};
    vecs[9] = '{1'b0, 1'b1, 2'd0, 8'h88, 4'h0, 1'b1, 4'b0001, 1'b1, 0, 8'h88};
    foreach (vecs[i]) begin
      apply(vecs[i].fl, vecs[i].v, vecs[i].sel, vecs[i].d, vecs[i].ordy);
      $display("vec %0d: flush=%0b valid=%0b sel=%0d data=%h out_ready=%b",
               i, vecs[i].fl, vecs[i].v, vecs[i].sel, vecs[i].d, vecs[i].ordy);
      chk("vec in_ready", 32'(in_ready), 32'(vecs[i].exp_rdy));
      edge_step();
      chk("vec out_valid", 32'(out_valid), 32'(vecs[i].exp_ov));
      if (vecs[i].chk_en)
        chk("vec out_data", 32'(lane_data(vecs[i].chk_lane)), 32'(vecs[i].chk_data));
    end

    // ---------------- streaming: 16 words, lane 0 ----------------
    do_reset();
    for (int i = 0; i < 16; i++) begin
      apply(1'b0, 1'b1, 2'd0, 8'(i), 4'b0001);
      $display("stream: word %h -> lane 0", 8'(i));
      chk("stream in_ready", 32'(in_ready), 32'h1);
      edge_step();
      chk("stream out_valid0", 32'(out_valid[0]), 32'h1);
      chk("stream out_data0", 32'(lane_data(0)), 32'(i));
    end
    apply(1'b0, 1'b0, 2'd0, 8'h00, 4'b0001);
    edge_step();
    chk("stream drained", 32'(out_valid), 32'h0);

    // ---------------- flush with all lanes full ----------------
    for (int k = 0; k < 4; k++) begin
      apply(1'b0, 1'b1, 2'(k), 8'(8'hC0 + k), 4'h0);
      edge_step();
    end
    chk("flush prefill", 32'(out_valid), 32'hF);
    apply(1'b1, 1'b1, 2'd0, 8'hEE, 4'hF);
    $display("flush: asserted with in_valid=1");
    chk("flush in_ready", 32'(in_ready), 32'h0);
    edge_step();
    chk("flush out_valid", 32'(out_valid), 32'h0);
    apply(1'b0, 1'b0, 2'd0, 8'h00, 4'h0);
    edge_step();
    chk("flush no accept", 32'(out_valid), 32'h0);

    // ---------------- async reset mid-stream ----------------
    for (int k = 0; k < 4; k++) begin
      apply(1'b0, 1'b1, 2'(k), 8'(8'hD0 + k), 4'h0);
      edge_step();
    end
    apply(1'b0, 1'b0, 2'd0, 8'h00, 4'h0);
    chk("areset prefill", 32'(out_valid), 32'hF);
    #1;
    rst = 1'b1;
    #1;
    $display("areset: rst asserted between edges");
    chk("areset out_valid", 32'(out_valid), 32'h0);
    chk("areset out_data", out_data, 32'h0);
    #2;
    rst = 1'b0;
    edge_step();
    chk("areset after release", 32'(out_valid), 32'h0);
    chk("areset in_ready", 32'(in_ready), 32'h1);

`ifdef DEMUX_COUNT_EN
    // ---------------- counter wrap on lane 3 (counts are 0 here) ----------------
    for (int i = 0; i < 17; i++) begin
      apply(1'b0, 1'b1, 2'd3, 8'(i), 4'b1000);
      edge_step();
    end
    apply(1'b0, 1'b0, 2'd0, 8'h00, 4'b1000);
    edge_step();
    $display("count: 17 transfers on lane 3");
    chk("cnt lane3 wrap", 32'(out_cnt[15:12]), 32'h1);
    chk("cnt lanes 0-2", 32'(out_cnt[11:0]), 32'h0);
    apply(1'b0, 1'b1, 2'd3, 8'h99, 4'h0);
    edge_step();
    apply(1'b1, 1'b0, 2'd0, 8'h00, 4'h0);
    edge_step();
    chk("cnt after flush", 32'(out_cnt[15:12]), 32'h1);
    chk("cnt flush out_valid", 32'(out_valid), 32'h0);
`endif

    // ---------------- randomized traffic against the model ----------------
    do_reset();
    for (int n = 0; n < 300; n++) rand_cycle(n);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/demux1to4_stream.md
DEMUX1TO4_STREAM -- requirements
Module: demux1to4_stream

Interface
REQ-001 Parameter: DATA_W, default 8, payload width in bits.
REQ-002 Parameter: CNT_W, default 16, per-lane transfer counter width (used only with DEMUX_COUNT_EN).
REQ-003 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous, active-high.
REQ-005 Port: flush  input  1  synchronous clear of all lane registers.
REQ-006 Port: in_valid  input  1  upstream word present.
REQ-007 Port: in_ready  output  1  block accepts the upstream word this cycle.
REQ-008 Port: in_sel  input  2  destination lane 0..3.
REQ-009 Port: in_data  input  DATA_W  upstream payload.
REQ-010 Port: out_valid  output  4  per-lane word present; bit k is lane k.
REQ-011 Port: out_ready  input  4  per-lane downstream accept.
REQ-012 Port: out_data  output  4*DATA_W  lane k payload at bits [k*DATA_W +: DATA_W].
REQ-013 Port: out_cnt  output  4*CNT_W  lane k accepted-transfer count; present only with DEMUX_COUNT_EN.

Function
REQ-014 Upstream transfer occurs when in_valid && in_ready; downstream lane-k transfer occurs when out_valid[k] && out_ready[k].
REQ-015 Each lane is a one-entry register with states EMPTY (out_valid[k]=0) and FULL (out_valid[k]=1).
REQ-016 in_ready = !flush && (!out_valid[in_sel] || out_ready[in_sel]); combinational, independent of in_valid.
REQ-017 Upstream transfer to lane k loads in_data into lane k and sets it FULL on the next edge; latency in->out exactly 1 cycle.
REQ-018 Lane k FULL with a downstream transfer and no upstream transfer to k: goes EMPTY.
REQ-019 Lane k FULL with simultaneous downstream and upstream transfer to k: reloads new data, stays FULL (full throughput, no bubble).
REQ-020 Lanes not addressed by in_sel are unaffected by upstream activity; a stalled lane never blocks traffic to other lanes.
REQ-021 out_data[k] holds stable while out_valid[k]=1 and out_ready[k]=0.
REQ-022 out_data of an EMPTY lane holds its last value (content is don't-care for checking).
REQ-023 in_sel/in_data are sampled only on an upstream transfer; changes while in_ready=0 have no effect.
REQ-024 flush=1: all lanes go EMPTY on the next edge, in_ready=0, no word accepted that cycle; flush overrides simultaneous upstream/downstream transfers.

Reset
REQ-025 rst=1 asynchronously forces all lanes EMPTY: out_valid=4'b0000, out_data=0, out_cnt=0.
REQ-026 in_ready is 1 after reset release when flush=0 (all lanes EMPTY).
REQ-027 Reset mid-transfer discards held words; no partial output appears after release.

Configuration
REQ-028 Macro DEMUX_COUNT_EN: when defined, each lane has a CNT_W-bit counter incremented on every downstream transfer of that lane, wrapping from all-ones to 0, cleared by rst, not cleared by flush, driven on out_cnt.
REQ-029 Without DEMUX_COUNT_EN: no counters and no out_cnt port; all other behaviour identical.

Structure
REQ-030 Package demux_pkg holds: N_LANES=4, SEL_W=2, and the lane-state enum {LANE_EMPTY, LANE_FULL}.
REQ-031 Sub-module demux_lane_reg implements one lane (state, data register, optional counter); the top instantiates it N_LANES times plus the in_ready select logic.

Verification
REQ-032 Reset then single word: in_sel=2, in_data=8'hA5, out_ready=4'b1111 -> next cycle out_valid=4'b0100, out_data[lane2]=8'hA5, then lane 2 EMPTY.
REQ-033 Back-pressure: lane 1 FULL with 8'h11, out_ready[1]=0, offer 8'h22 to lane 1 -> in_ready=0, lane 1 holds 8'h11; offer 8'h33 to lane 3 -> accepted, out_valid=4'b1010.
REQ-034 Streaming: 16 consecutive words 0x00..0x0F to lane 0 with out_ready[0]=1 -> in_ready stays 1, lane 0 outputs 0x00..0x0F on consecutive cycles, 1-cycle latency.
REQ-035 Flush: all four lanes FULL, assert flush with in_valid=1 -> in_ready=0, next cycle out_valid=4'b0000, no word accepted.
REQ-036 Async reset mid-stream: assert rst between clock edges while lanes FULL -> out_valid=0 immediately, before the next edge.
REQ-037 With DEMUX_COUNT_EN, CNT_W=4: 17 transfers on lane 3 -> out_cnt[lane3]=1 (wrap), other lanes 0; flush leaves the count unchanged.
